// File: rtl/stable_matching_pref_loader.sv
// Serial loader that packs receiver then sender preference entries into the flat frame
// consumed by the combinational stable-matching core, with a valid/ready frame handoff.
module stable_matching_pref_loader #(
  parameter int Ks = 4,
  parameter int Kr = Ks,
  parameter int S  = 4,
  parameter int R  = S,
  localparam int LOGS = (S > 1) ? $clog2(S) : 1,
  localparam int LOGR = (R > 1) ? $clog2(R) : 1,
  localparam int W    = (LOGS > LOGR) ? LOGS : LOGR,
  localparam int P    = R * Kr * LOGS + S * Ks * LOGR
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         frame_valid,
  input  logic         frame_ready,
  output logic [P-1:0] p_input,
  output logic         frame_err
);

  localparam int NB    = R * Kr;
  localparam int NA    = S * Ks;
  localparam int NMAX  = (NB > NA) ? NB : NA;
  localparam int CNTW  = $clog2(NMAX + 1);
  localparam int A_OFS = NB * LOGS;

  localparam logic [W:0]      S_LIM  = (W + 1)'(S);
  localparam logic [W:0]      R_LIM  = (W + 1)'(R);
  localparam logic [CNTW-1:0] LAST_B = CNTW'(NB - 1);
  localparam logic [CNTW-1:0] LAST_A = CNTW'(NA - 1);

  typedef enum logic [1:0] {LOAD_B, LOAD_A, FULL} state_t;

  state_t          state_q;
  logic [CNTW-1:0] cnt_q;
  logic [P-1:0]    p_input_q;
  logic            frame_valid_q;
  logic            frame_err_q;
  logic            frame_err_d;
  logic            accept;
  logic            beat_err;

  assign in_ready    = (state_q != FULL);
  assign accept      = in_valid & in_ready;
  assign p_input     = p_input_q;
  assign frame_valid = frame_valid_q;
  assign frame_err   = frame_err_q;

  // The first accepted beat of a frame drops the previous frame's error before adding its own.
  always_comb begin
    beat_err    = 1'b0;
    frame_err_d = frame_err_q;
    if (state_q == LOAD_B) begin
      beat_err = ({1'b0, in_data} >= S_LIM);
    end else if (state_q == LOAD_A) begin
      beat_err = ({1'b0, in_data} >= R_LIM);
    end
    if (accept) begin
      frame_err_d = ((state_q == LOAD_B && cnt_q == '0) ? 1'b0 : frame_err_q) | beat_err;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= LOAD_B;
      cnt_q         <= '0;
      p_input_q     <= '0;
      frame_valid_q <= 1'b0;
      frame_err_q   <= 1'b0;
    end else begin
      frame_err_q <= frame_err_d;
      case (state_q)
        LOAD_B: begin
          if (accept) begin
            p_input_q[int'(cnt_q) * LOGS +: LOGS] <= in_data[LOGS-1:0];
            if (cnt_q == LAST_B) begin
              cnt_q   <= '0;
              state_q <= LOAD_A;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        LOAD_A: begin
          if (accept) begin
            p_input_q[A_OFS + int'(cnt_q) * LOGR +: LOGR] <= in_data[LOGR-1:0];
            if (cnt_q == LAST_A) begin
              cnt_q         <= '0;
              state_q       <= FULL;
              frame_valid_q <= 1'b1;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        FULL: begin
          // Old frame bits are left in place; the next frame overwrites them beat by beat.
          if (frame_ready) begin
            state_q       <= LOAD_B;
            cnt_q         <= '0;
            frame_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q       <= LOAD_B;
          cnt_q         <= '0;
          frame_valid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule
